id_ex_stage_reg: RTL and testbench

//  ID/EX pipeline register. Sits directly downstream of the decode-stage control pass-through.

---
 rtl/id_ex_stage_reg.sv | 142 ++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, external stall and branch flush.
// Optional perf counters (bubbles, flushes) are built when IDEX_PERF_CNT_EN is defined.
module id_ex_stage_reg #(
    parameter int XLEN = 32
`ifdef IDEX_PERF_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [1:0]      IN_ALUOp,
    input  logic            IN_ALUSrc,
    input  logic            IN_Branch,
    input  logic            IN_MemRead,
    input  logic            IN_MemWrite,
    input  logic            IN_RegWrite,
    input  logic            IN_MemToReg,
    input  logic            IN_Valid,
    input  logic [XLEN-1:0] IN_PC,
    input  logic [XLEN-1:0] IN_RD1,
    input  logic [XLEN-1:0] IN_RD2,
    input  logic [XLEN-1:0] IN_Imm,
    input  logic [4:0]      IN_Rs1,
    input  logic [4:0]      IN_Rs2,
    input  logic [4:0]      IN_Rd,
    input  logic [3:0]      IN_Funct,
    input  logic            IN_Stall,
    input  logic            IN_Flush,
    output logic [1:0]      OUT_ALUOp,
    output logic            OUT_ALUSrc,
    output logic            OUT_Branch,
    output logic            OUT_MemRead,
    output logic            OUT_MemWrite,
    output logic            OUT_RegWrite,
    output logic            OUT_MemToReg,
    output logic            OUT_Valid,
    output logic [XLEN-1:0] OUT_PC,
    output logic [XLEN-1:0] OUT_RD1,
    output logic [XLEN-1:0] OUT_RD2,
    output logic [XLEN-1:0] OUT_Imm,
    output logic [4:0]      OUT_Rs1,
    output logic [4:0]      OUT_Rs2,
    output logic [4:0]      OUT_Rd,
    output logic [3:0]      OUT_Funct,
    output logic            OUT_HazardStall
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] OUT_BubbleCnt,
    output logic [CNT_W-1:0] OUT_FlushCnt
`endif
);

    logic usesRs2;
    logic rdMatch;
    logic hazard;
    logic bubble;
    logic loadAll;

    // A load in EX whose rd feeds the instruction in ID cannot forward in time.
    always_comb begin
        usesRs2 = ~IN_ALUSrc | IN_MemWrite | IN_Branch;
        rdMatch = (OUT_Rd == IN_Rs1) | (usesRs2 & (OUT_Rd == IN_Rs2));
        hazard  = OUT_Valid & OUT_MemRead & (OUT_Rd != 5'd0) & IN_Valid & rdMatch;
    end

    // Stall holds everything, including a pending hazard; flush outranks both.
    assign OUT_HazardStall = hazard & ~IN_Flush;
    assign bubble          = IN_Flush | (~IN_Stall & hazard);
    assign loadAll         = ~IN_Flush & ~IN_Stall & ~hazard;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            OUT_ALUOp    <= 2'b00;
            OUT_ALUSrc   <= 1'b0;
            OUT_Branch   <= 1'b0;
            OUT_MemRead  <= 1'b0;
            OUT_MemWrite <= 1'b0;
            OUT_RegWrite <= 1'b0;
            OUT_MemToReg <= 1'b0;
            OUT_Valid    <= 1'b0;
        end else if (bubble) begin
            OUT_ALUOp    <= 2'b00;
            OUT_ALUSrc   <= 1'b0;
            OUT_Branch   <= 1'b0;
            OUT_MemRead  <= 1'b0;
            OUT_MemWrite <= 1'b0;
            OUT_RegWrite <= 1'b0;
            OUT_MemToReg <= 1'b0;
            OUT_Valid    <= 1'b0;
        end else if (loadAll) begin
            OUT_ALUOp    <= IN_ALUOp;
            OUT_ALUSrc   <= IN_ALUSrc;
            OUT_Branch   <= IN_Branch;
            OUT_MemRead  <= IN_MemRead;
            OUT_MemWrite <= IN_MemWrite;
            OUT_RegWrite <= IN_RegWrite;
            OUT_MemToReg <= IN_MemToReg;
            OUT_Valid    <= IN_Valid;
        end
    end

    // Data and index fields keep their old values through a bubble.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            OUT_PC    <= '0;
            OUT_RD1   <= '0;
            OUT_RD2   <= '0;
            OUT_Imm   <= '0;
            OUT_Rs1   <= 5'd0;
            OUT_Rs2   <= 5'd0;
            OUT_Rd    <= 5'd0;
            OUT_Funct <= 4'd0;
        end else if (loadAll) begin
            OUT_PC    <= IN_PC;
            OUT_RD1   <= IN_RD1;
            OUT_RD2   <= IN_RD2;
            OUT_Imm   <= IN_Imm;
            OUT_Rs1   <= IN_Rs1;
            OUT_Rs2   <= IN_Rs2;
            OUT_Rd    <= IN_Rd;
            OUT_Funct <= IN_Funct;
        end
    end

`ifdef IDEX_PERF_CNT_EN
    logic hazardBubble;
    assign hazardBubble = ~IN_Flush & ~IN_Stall & hazard;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            OUT_BubbleCnt <= '0;
            OUT_FlushCnt  <= '0;
        end else begin
            if (hazardBubble && (OUT_BubbleCnt != {CNT_W{1'b1}}))
                OUT_BubbleCnt <= OUT_BubbleCnt + 1'b1;
            if (IN_Flush && (OUT_FlushCnt != {CNT_W{1'b1}}))
                OUT_FlushCnt <= OUT_FlushCnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: reference model feeds an expected queue per edge.
// Define IDEX_PERF_CNT_EN to also exercise the saturating perf counters (CNT_W=2).
module tb_id_ex_stage_reg;
    localparam int XLEN = 32;
    localparam int W    = 9 + 4 * XLEN + 15 + 4;

    logic            CLK = 1'b0;
    logic            rstN;
    logic [1:0]      inAluOp;
    logic            inAluSrc, inBranch, inMemRead, inMemWrite, inRegWrite, inMemToReg, inValid;
    logic [XLEN-1:0] inPc, inRd1, inRd2, inImm;
    logic [4:0]      inRs1, inRs2, inRd;
    logic [3:0]      inFunct;
    logic            inStall, inFlush;

    logic [1:0]      outAluOp;
    logic            outAluSrc, outBranch, outMemRead, outMemWrite, outRegWrite, outMemToReg, outValid;
    logic [XLEN-1:0] outPc, outRd1, outRd2, outImm;
    logic [4:0]      outRs1, outRs2, outRd;
    logic [3:0]      outFunct;
    logic            outHazardStall;
`ifdef IDEX_PERF_CNT_EN
    logic [1:0]      outBubbleCnt, outFlushCnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    // Reference model of the registered outputs.
    logic [8:0]      mCtl = '0;  // {valid, aluop[1:0], alusrc, branch, memread, memwrite, regwrite, memtoreg}
    logic [XLEN-1:0] mPc = '0, mRd1 = '0, mRd2 = '0, mImm = '0;
    logic [4:0]      mRs1 = '0, mRs2 = '0, mRd = '0;
    logic [3:0]      mFunct = '0;

    id_ex_stage_reg #(
        .XLEN(XLEN)
`ifdef IDEX_PERF_CNT_EN
        , .CNT_W(2)
`endif
    ) dut (
        .CLK(CLK), .RST_N(rstN),
        .IN_ALUOp(inAluOp), .IN_ALUSrc(inAluSrc), .IN_Branch(inBranch), .IN_MemRead(inMemRead),
        .IN_MemWrite(inMemWrite), .IN_RegWrite(inRegWrite), .IN_MemToReg(inMemToReg),
        .IN_Valid(inValid), .IN_PC(inPc), .IN_RD1(inRd1), .IN_RD2(inRd2), .IN_Imm(inImm),
        .IN_Rs1(inRs1), .IN_Rs2(inRs2), .IN_Rd(inRd), .IN_Funct(inFunct),
        .IN_Stall(inStall), .IN_Flush(inFlush),
        .OUT_ALUOp(outAluOp), .OUT_ALUSrc(outAluSrc), .OUT_Branch(outBranch),
        .OUT_MemRead(outMemRead), .OUT_MemWrite(outMemWrite), .OUT_RegWrite(outRegWrite),
        .OUT_MemToReg(outMemToReg), .OUT_Valid(outValid), .OUT_PC(outPc), .OUT_RD1(outRd1),
        .OUT_RD2(outRd2), .OUT_Imm(outImm), .OUT_Rs1(outRs1), .OUT_Rs2(outRs2), .OUT_Rd(outRd),
        .OUT_Funct(outFunct), .OUT_HazardStall(outHazardStall)
`ifdef IDEX_PERF_CNT_EN
        , .OUT_BubbleCnt(outBubbleCnt), .OUT_FlushCnt(outFlushCnt)
`endif
    );

    // Clock / reset block
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] packModel();
        return {mCtl, mPc, mRd1, mRd2, mImm, mRs1, mRs2, mRd, mFunct};
    endfunction

    function automatic logic [W-1:0] packDut();
        return {outValid, outAluOp, outAluSrc, outBranch, outMemRead, outMemWrite, outRegWrite,
                outMemToReg, outPc, outRd1, outRd2, outImm, outRs1, outRs2, outRd, outFunct};
    endfunction

    function automatic logic modelHazard();
        logic useRs2;
        useRs2 = !inAluSrc || inMemWrite || inBranch;
        return mCtl[8] && mCtl[3] && (mRd != 5'd0) && inValid &&
               ((mRd == inRs1) || (useRs2 && (mRd == inRs2)));
    endfunction

    // Driver tasks
    task automatic setInstr(input logic v, input logic [1:0] op, input logic src, input logic br,
                            input logic mr, input logic mw, input logic rw, input logic m2r,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                            input logic [XLEN-1:0] pc, input logic [XLEN-1:0] d1,
                            input logic [XLEN-1:0] d2, input logic [XLEN-1:0] imm,
                            input logic [3:0] fn);
        inValid = v; inAluOp = op; inAluSrc = src; inBranch = br; inMemRead = mr;
        inMemWrite = mw; inRegWrite = rw; inMemToReg = m2r; inRs1 = rs1; inRs2 = rs2; inRd = rd;
        inPc = pc; inRd1 = d1; inRd2 = d2; inImm = imm; inFunct = fn;
    endtask

    task automatic setNop();
        setInstr(0, 2'b00, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, '0, '0, '0, '0, 4'd0);
    endtask

    task automatic setLoad(input logic [4:0] rd, input logic [4:0] rs1, input logic [XLEN-1:0] pc);
        setInstr(1, 2'b00, 1, 0, 1, 0, 1, 1, rs1, 5'd9, rd, pc, 32'h1000, 32'h0, 32'h10, 4'd2);
    endtask

    task automatic setAdd(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [XLEN-1:0] pc);
        setInstr(1, 2'b10, 0, 0, 0, 0, 1, 0, rs1, rs2, rd, pc, 32'd5, 32'd7, 32'h0, 4'd0);
    endtask

    // One clock edge. expHaz: 0/1 = required OUT_HazardStall, -1 = use model, -2 = skip.
    task automatic step(input int expHaz, input string name);
        logic h;
        logic [W-1:0] exp;
        logic [W-1:0] got;
        logic raw;
        #1;
        raw = modelHazard();
        if (expHaz != -2) begin
            h = (expHaz == -1) ? (raw && !inFlush) : expHaz[0];
            checks++;
            if (outHazardStall !== h) begin
                errors++;
                $display("FAIL %s hazard: got %b want %b", name, outHazardStall, h);
            end
        end
        if (!rstN) begin
            mCtl = '0; mPc = '0; mRd1 = '0; mRd2 = '0; mImm = '0;
            mRs1 = '0; mRs2 = '0; mRd = '0; mFunct = '0;
        end else if (inFlush || (!inStall && raw)) begin
            mCtl = '0;
        end else if (!inStall) begin
            mCtl = {inValid, inAluOp, inAluSrc, inBranch, inMemRead, inMemWrite, inRegWrite, inMemToReg};
            mPc = inPc; mRd1 = inRd1; mRd2 = inRd2; mImm = inImm;
            mRs1 = inRs1; mRs2 = inRs2; mRd = inRd; mFunct = inFunct;
        end
        exp_q.push_back(packModel());
        @(posedge CLK);
        #1;
        exp = exp_q.pop_front();
        got = packDut();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s outputs: got %h want %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rstN = 0; inStall = 1; inFlush = 1;
        setInstr(1, 2'b11, 1, 1, 1, 1, 1, 1, 5'h1f, 5'h1f, 5'h1f, '1, '1, '1, '1, 4'hf);
        step(-2, "reset_edge1");
        step(0, "reset_edge2");
        checks++;
        if (packDut() !== '0) begin
            errors++;
            $display("FAIL reset_zero: got %h want 0", packDut());
        end
        rstN = 1; inStall = 0; inFlush = 0;
        setNop();
        step(0, "post_reset_nop");
    endtask

    task automatic test_load();
        setAdd(5'd3, 5'd1, 5'd2, 32'h100);
        step(0, "load_add");
        checks++;
        if (outValid !== 1'b1 || outRd !== 5'd3 || outRd1 !== 32'd5 || outRd2 !== 32'd7 || outAluOp !== 2'b10) begin
            errors++;
            $display("FAIL load_fields: got v=%b rd=%0d rd1=%0d rd2=%0d op=%b want 1 3 5 7 10",
                     outValid, outRd, outRd1, outRd2, outAluOp);
        end
    endtask

    task automatic test_load_use();
        setLoad(5'd5, 5'd1, 32'h104);
        step(0, "lu_load");
        setAdd(5'd6, 5'd5, 5'd2, 32'h108);
        step(1, "lu_bubble");
        checks++;
        if (outValid !== 1'b0 || outMemRead !== 1'b0 || outRegWrite !== 1'b0) begin
            errors++;
            $display("FAIL lu_bubble_ctl: got v=%b mr=%b rw=%b want 0 0 0", outValid, outMemRead, outRegWrite);
        end
        step(0, "lu_reissue");
        checks++;
        if (outValid !== 1'b1 || outPc !== 32'h108) begin
            errors++;
            $display("FAIL lu_reissue_pc: got v=%b pc=%h want 1 108", outValid, outPc);
        end
    endtask

    task automatic test_no_false_hazard();
        setLoad(5'd0, 5'd1, 32'h200);
        step(0, "nf_load_x0");
        setAdd(5'd4, 5'd0, 5'd0, 32'h204);
        step(0, "nf_use_x0");
        setLoad(5'd5, 5'd1, 32'h208);
        step(0, "nf_load_x5");
        setInstr(1, 2'b00, 1, 0, 0, 0, 1, 0, 5'd1, 5'd5, 5'd6, 32'h20c, 32'd1, 32'd2, 32'd3, 4'd0);
        step(0, "nf_addi_rs2field");
    endtask

    task automatic test_flush_stall();
        setLoad(5'd5, 5'd1, 32'h300);
        step(0, "fs_load");
        setAdd(5'd6, 5'd5, 5'd2, 32'h304);
        inFlush = 1;
        step(0, "fs_flush_overrides");
        inFlush = 0;
        step(0, "fs_after_flush");
        setAdd(5'd7, 5'd8, 5'd9, 32'h308);
        inStall = 1;
        for (int i = 0; i < 3; i++) step(0, "fs_stall_hold");
        checks++;
        if (outPc !== 32'h304) begin
            errors++;
            $display("FAIL fs_frozen_pc: got %h want 304", outPc);
        end
        inStall = 0;
        step(0, "fs_release");
        setLoad(5'd7, 5'd1, 32'h30c);
        step(0, "fs_load2");
        setAdd(5'd8, 5'd3, 5'd7, 32'h310);
        inStall = 1;
        step(1, "fs_stall_hazard1");
        step(1, "fs_stall_hazard2");
        inStall = 0;
        step(1, "fs_hazard_bubble");
        step(0, "fs_hazard_reissue");
    endtask

    task automatic test_reset_mid();
        setAdd(5'd9, 5'd1, 5'd2, 32'h400);
        step(0, "rm_load");
        rstN = 0;
        step(0, "rm_reset");
        rstN = 1;
        setNop();
        step(0, "rm_after");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            setInstr($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 1),
                     $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                     $urandom_range(0, 1), $urandom_range(0, 1), 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom, $urandom,
                     $urandom, $urandom, 4'($urandom_range(0, 15)));
            inStall = ($urandom_range(0, 4) == 0);
            inFlush = ($urandom_range(0, 6) == 0);
            step(-1, "random");
        end
        inStall = 0; inFlush = 0;
    endtask

`ifdef IDEX_PERF_CNT_EN
    task automatic test_perf();
        rstN = 0; setNop();
        step(0, "perf_reset");
        rstN = 1;
        for (int i = 0; i < 5; i++) begin
            setLoad(5'd5, 5'd1, 32'h500);
            step(0, "perf_load");
            setAdd(5'd6, 5'd5, 5'd2, 32'h504);
            step(1, "perf_bubble");
            step(0, "perf_reissue");
        end
        inFlush = 1;
        step(0, "perf_flush");
        inFlush = 0;
        checks++;
        if (outBubbleCnt !== 2'd3) begin
            errors++;
            $display("FAIL perf_bubble_cnt: got %0d want 3", outBubbleCnt);
        end
        checks++;
        if (outFlushCnt !== 2'd1) begin
            errors++;
            $display("FAIL perf_flush_cnt: got %0d want 1", outFlushCnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_load_use();
        test_no_false_hazard();
        test_flush_stall();
        test_reset_mid();
        test_random();
`ifdef IDEX_PERF_CNT_EN
        test_perf();
`endif
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
